// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART TX arbiter
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_FIFO_CNT_W = 5;

  // Round-robin successor of a requester index.
  function automatic logic [2:0] rr_next(input logic [2:0] id, input int n);
    return (int'(id) == n - 1) ? 3'd0 : id + 3'd1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and TX FIFO side signals of the arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*8-1:0]       req_data;
  logic [NUM_REQ-1:0]         req_last;
  logic [NUM_REQ-1:0]         req_ready;
  logic [UART_FIFO_CNT_W-1:0] tx_fifo_count;
  logic                       tx_fifo_push;
  logic [7:0]                 tx_wdata;
  logic                       grant_valid;
  logic [2:0]                 grant_id;
  logic                       timeout_err;

  modport master (
    output req_valid, req_data, req_last, tx_fifo_count,
    input  req_ready, tx_fifo_push, tx_wdata, grant_valid, grant_id, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_fifo_count,
    output req_ready, tx_fifo_push, tx_wdata, grant_valid, grant_id, timeout_err
  );

endinterface

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - rotate-priority picker: first set request at or after ptr
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [2:0]         ptr_i,
  output logic [2:0]         idx_o,
  output logic               any_o
);
  logic [NUM_REQ-1:0] rot;
  logic [3:0]         sum;

  // Scan downward so the lowest rotated position (closest to ptr) wins.
  always_comb begin
    rot   = NUM_REQ'({req_i, req_i} >> ptr_i);
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr_i} + 4'(k);
        if (sum >= 4'(NUM_REQ)) begin
          sum = sum - 4'(NUM_REQ);
        end
        idx_o = sum[2:0];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin sharing of one UART TX FIFO
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 32
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  uart_tx_arbiter_if.slave bus
);
  localparam logic [7:0]  BURST_LAST = 8'(MAX_BURST - 1);
  localparam bit          STALL_EN   = (TIMEOUT != 0);
  localparam logic [15:0] STALL_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  arb_state_t         state_q, state_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic               grant_valid_q, grant_valid_d;
  logic [7:0]         burst_cnt_q, burst_cnt_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;
  logic               push_q, push_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               timeout_err_q, timeout_err_d;

  logic [NUM_REQ-1:0] ready_c;
  logic [5:0]         occupancy;
  logic               space_ok;
  logic               g_valid, g_last;
  logic [7:0]         g_data;
  logic [2:0]         pick_idx;
  logic               pick_any;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // The push still in flight is counted so the FIFO is never pushed while full.
  assign occupancy = {1'b0, bus.tx_fifo_count} + {5'd0, push_q};
  assign space_ok  = occupancy < 6'(UART_FIFO_DEPTH);

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == grant_id_q) begin
        g_valid = bus.req_valid[i];
        g_last  = bus.req_last[i];
        g_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    burst_cnt_d   = burst_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    push_d        = 1'b0;
    wdata_d       = wdata_q;
    timeout_err_d = 1'b0;
    ready_c       = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d       = XFER;
          grant_id_d    = pick_idx;
          grant_valid_d = 1'b1;
          burst_cnt_d   = '0;
          stall_cnt_d   = '0;
        end
      end
      XFER: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (3'(i) == grant_id_q) begin
            ready_c[i] = space_ok;
          end
        end
        if (g_valid && space_ok) begin
          push_d      = 1'b1;
          wdata_d     = g_data;
          burst_cnt_d = burst_cnt_q + 8'd1;
          stall_cnt_d = '0;
          if (g_last || burst_cnt_q == BURST_LAST) begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
            rr_ptr_d      = rr_next(grant_id_q, NUM_REQ);
          end
        end else if (!g_valid && STALL_EN) begin
          if (stall_cnt_q == STALL_LAST) begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
            rr_ptr_d      = rr_next(grant_id_q, NUM_REQ);
            timeout_err_d = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      burst_cnt_q   <= '0;
      stall_cnt_q   <= '0;
      push_q        <= 1'b0;
      wdata_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      burst_cnt_q   <= burst_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      push_q        <= push_d;
      wdata_q       <= wdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.req_ready    = ready_c;
  assign bus.tx_fifo_push = push_q;
  assign bus.tx_wdata     = wdata_q;
  assign bus.grant_valid  = grant_valid_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;

  logic PCLK;
  logic PRESETn;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   terr_seen = 0;

  logic [8:0] src_q [NUM_REQ][$];
  logic [7:0] log_q [$];
  logic [7:0] exp_q [$];

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(4), .TIMEOUT(8)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus.slave)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic q_push(input int r, input logic [7:0] d, input logic l);
    src_q[r].push_back({l, d});
  endtask

  task automatic drive();
    logic [NUM_REQ-1:0]   v, l;
    logic [NUM_REQ*8-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        v[i]       = 1'b1;
        l[i]       = src_q[i][0][8];
        d[8*i +: 8] = src_q[i][0][7:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    #1;
  endtask

  // One clock: record what the coming edge accepts, then log outputs at the next negedge.
  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    acc = bus.req_valid & bus.req_ready & {NUM_REQ{PRESETn}};
    @(negedge PCLK);
    if (bus.tx_fifo_push) log_q.push_back(bus.tx_wdata);
    if (bus.timeout_err) terr_seen++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive();
  endtask

  task automatic set_count(input logic [4:0] c);
    bus.tx_fifo_count = c;
    #1;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      tick();
      done = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() > 0) done = 1'b0;
      if (bus.grant_valid || bus.tx_fifo_push) done = 1'b0;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic expect_log(input string tag);
    check({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    end
    log_q.delete();
  endtask

  initial begin
    PRESETn           = 1'b0;
    bus.req_valid     = '0;
    bus.req_data      = '0;
    bus.req_last      = '0;
    bus.tx_fifo_count = '0;
    repeat (3) tick();
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_push", 32'(bus.tx_fifo_push), 32'd0);
    check("rst_wdata", 32'(bus.tx_wdata), 32'd0);
    check("rst_gvalid", 32'(bus.grant_valid), 32'd0);
    check("rst_gid", 32'(bus.grant_id), 32'd0);
    check("rst_terr", 32'(bus.timeout_err), 32'd0);
    PRESETn = 1'b1;
    tick();

    // Single message from req0
    q_push(0, 8'h11, 1'b0); q_push(0, 8'h22, 1'b0); q_push(0, 8'h33, 1'b1);
    drive();
    tick();
    check("t1_gvalid", 32'(bus.grant_valid), 32'd1);
    check("t1_gid", 32'(bus.grant_id), 32'd0);
    check("t1_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    check("t1_push0", 32'(bus.tx_fifo_push), 32'd1);
    check("t1_data0", 32'(bus.tx_wdata), 32'h11);
    tick();
    check("t1_push1", 32'(bus.tx_fifo_push), 32'd1);
    check("t1_data1", 32'(bus.tx_wdata), 32'h22);
    tick();
    check("t1_push2", 32'(bus.tx_fifo_push), 32'd1);
    check("t1_data2", 32'(bus.tx_wdata), 32'h33);
    check("t1_gvalid_end", 32'(bus.grant_valid), 32'd0);
    check("t1_gid_end", 32'(bus.grant_id), 32'd0);
    tick();
    check("t1_push_idle", 32'(bus.tx_fifo_push), 32'd0);
    log_q.delete();

    // Round-robin order from rr_ptr=0: req0, then req2 ahead of req0's second message
    PRESETn = 1'b0; tick(); PRESETn = 1'b1; tick();
    q_push(0, 8'hA1, 1'b1); q_push(0, 8'hA2, 1'b1);
    q_push(2, 8'hC1, 1'b0); q_push(2, 8'hC2, 1'b1);
    drive();
    tick();
    check("t2_first_gid", 32'(bus.grant_id), 32'd0);
    drain("t2_done");
    exp_q = '{8'hA1, 8'hC1, 8'hC2, 8'hA2};
    expect_log("t2_order");

    // FIFO nearly full; backpressure is not a stall
    terr_seen = 0;
    set_count(5'd15);
    q_push(1, 8'hB0, 1'b0); q_push(1, 8'hB1, 1'b0); q_push(1, 8'hB2, 1'b1);
    drive();
    tick();
    check("t3_gid", 32'(bus.grant_id), 32'd1);
    check("t3_ready_space", 32'(bus.req_ready), 32'b0010);
    tick();
    check("t3_push", 32'(bus.tx_fifo_push), 32'd1);
    check("t3_ready_inflight", 32'(bus.req_ready), 32'd0);
    set_count(5'd16);
    repeat (10) tick();
    check("t3_ready_full", 32'(bus.req_ready), 32'd0);
    check("t3_one_push", log_q.size(), 32'd1);
    check("t3_still_granted", 32'(bus.grant_valid), 32'd1);
    check("t3_no_timeout", terr_seen, 32'd0);
    set_count(5'd0);
    drain("t3_done");
    exp_q = '{8'hB0, 8'hB1, 8'hB2};
    expect_log("t3_order");

    // Burst limit of 4 lets req3 in between
    q_push(1, 8'hA0, 1'b0); q_push(1, 8'hA1, 1'b0); q_push(1, 8'hA2, 1'b0);
    q_push(1, 8'hA3, 1'b0); q_push(1, 8'hA4, 1'b0); q_push(1, 8'hA5, 1'b1);
    drive();
    tick();
    check("t4_gid", 32'(bus.grant_id), 32'd1);
    q_push(3, 8'hD0, 1'b0); q_push(3, 8'hD1, 1'b1);
    drive();
    drain("t4_done");
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hD0, 8'hD1, 8'hA4, 8'hA5};
    expect_log("t4_order");

    // Stall timeout of 8 cycles
    terr_seen = 0;
    q_push(0, 8'h5A, 1'b0);
    drive();
    tick();
    check("t5_gid", 32'(bus.grant_id), 32'd0);
    q_push(2, 8'hE0, 1'b1);
    drive();
    tick();
    repeat (7) tick();
    check("t5_no_early_terr", terr_seen, 32'd0);
    check("t5_gvalid_pre", 32'(bus.grant_valid), 32'd1);
    tick();
    check("t5_terr", 32'(bus.timeout_err), 32'd1);
    check("t5_gvalid_drop", 32'(bus.grant_valid), 32'd0);
    tick();
    check("t5_terr_pulse", 32'(bus.timeout_err), 32'd0);
    check("t5_next_gid", 32'(bus.grant_id), 32'd2);
    check("t5_next_gvalid", 32'(bus.grant_valid), 32'd1);
    drain("t5_done");
    check("t5_terr_count", terr_seen, 32'd1);
    exp_q = '{8'h5A, 8'hE0};
    expect_log("t5_order");

    // Reset mid-burst, req3 waiting so rr_ptr reset is observable
    q_push(0, 8'h61, 1'b0); q_push(0, 8'h62, 1'b0);
    q_push(0, 8'h63, 1'b0); q_push(0, 8'h64, 1'b1);
    drive();
    tick();
    check("t6_gid", 32'(bus.grant_id), 32'd0);
    tick(); tick(); tick();
    check("t6_push3", 32'(bus.tx_fifo_push), 32'd1);
    check("t6_data3", 32'(bus.tx_wdata), 32'h63);
    q_push(3, 8'hF0, 1'b1);
    PRESETn = 1'b0;
    drive();
    tick();
    check("t6_rst_push", 32'(bus.tx_fifo_push), 32'd0);
    check("t6_rst_wdata", 32'(bus.tx_wdata), 32'd0);
    check("t6_rst_gvalid", 32'(bus.grant_valid), 32'd0);
    check("t6_rst_gid", 32'(bus.grant_id), 32'd0);
    check("t6_rst_terr", 32'(bus.timeout_err), 32'd0);
    check("t6_rst_ready", 32'(bus.req_ready), 32'd0);
    PRESETn = 1'b1;
    tick();
    check("t6_regrant_gid", 32'(bus.grant_id), 32'd0);
    check("t6_regrant_gvalid", 32'(bus.grant_valid), 32'd1);
    drain("t6_done");
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'hF0};
    expect_log("t6_order");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
